// File: rtl/config_frame_pkg.sv
// -----------------------------------------------------------------------------
// config_frame_pkg
//   Shared constants and types for the frame configuration writer.
//   - SYNC_WORD / DESYNC_WORD : session delimiters recognised outside DATA.
//   - Address word layout     : flag bit, column field, frame field.
//   - state_e                 : writer FSM states. The state is also exported
//                               on the top's debug port.
//   - is_addr_word()          : address word classifier used in ADDR.
// -----------------------------------------------------------------------------
package config_frame_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [WORD_W-1:0] DESYNC_WORD = 32'hFAB0_FAB0;

    // Address word: bit 31 flags an address, [30:16] column, [7:0] frame.
    // Bits [15:8] are don't-care.
    localparam int ADDR_FLAG_BIT = 31;
    localparam int COL_LSB       = 16;
    localparam int COL_W         = 15;
    localparam int FRAME_LSB     = 0;
    localparam int FRAME_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    function automatic logic is_addr_word(input logic [WORD_W-1:0] word);
        return word[ADDR_FLAG_BIT];
    endfunction

endpackage : config_frame_pkg

// File: rtl/frame_strobe_decoder.sv
// -----------------------------------------------------------------------------
// frame_strobe_decoder
//   Purely combinational decode of a (column, frame) address into the one-hot
//   FrameStrobe vector. Bit c*MaxFramesPerCol+f belongs to column c, frame f.
//   An address outside the array raises range_err and yields an all-zero
//   vector, so a bad address can never pulse a strobe line.
// Ports
//   col       in   COL_W                       latched column address
//   frame     in   FRAME_W                     latched frame index
//   onehot    out  NumCols*MaxFramesPerCol     decoded strobe pattern
//   range_err out  1                           column or frame out of range
// -----------------------------------------------------------------------------
module frame_strobe_decoder
    import config_frame_pkg::*;
#(
    parameter int NumCols         = 8,
    parameter int MaxFramesPerCol = 20
) (
    input  logic [COL_W-1:0]                   col,
    input  logic [FRAME_W-1:0]                 frame,
    output logic [NumCols*MaxFramesPerCol-1:0] onehot,
    output logic                               range_err
);

    always_comb begin
        range_err = (col >= COL_W'(NumCols)) || (frame >= FRAME_W'(MaxFramesPerCol));
        onehot    = '0;
        for (int c = 0; c < NumCols; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                if (col == COL_W'(c) && frame == FRAME_W'(f)) begin
                    onehot[c*MaxFramesPerCol + f] = 1'b1;
                end
            end
        end
        if (range_err) begin
            onehot = '0;
        end
    end

endmodule : frame_strobe_decoder

// File: rtl/config_frame_writer.sv
// -----------------------------------------------------------------------------
// config_frame_writer
//   Writer side of the frame configuration interface. Consumes bitstream
//   words, assembles one frame (one 32-bit word per tile row, row 0 first)
//   and pulses the addressed column/frame FrameStrobe line once so tile
//   ConfigMem latches capture FrameData.
//
//   Word stream handshake: a word transfers on a rising CLK edge where both
//   in_valid and in_ready are high. in_ready does not depend on in_valid; it
//   is high in IDLE, ADDR and DATA and low in STROBE, HOLD and during reset.
//   The source may hold in_valid low for any number of cycles; the writer
//   simply waits.
//
//   Frame timing (last data word accepted at edge N):
//     edge N   : last row written into FrameData, FSM enters STROBE
//     edge N+1 : FrameStrobe bit rises (registered image of STROBE), -> HOLD
//     edge N+2 : FrameStrobe falls, FSM back in ADDR
//   FrameData is therefore stable one full cycle before the strobe rises and
//   at least one cycle after it falls (the next DATA write needs an address
//   word first).
//
// Ports
//   CLK          in   1                          clock
//   resetn       in   1                          async active-low reset
//   in_data      in   32                         bitstream word
//   in_valid     in   1                          word valid
//   in_ready     out  1                          writer can accept a word
//   FrameData    out  NumRows*FrameBitsPerRow    row r at [r*32 +: 32]
//   FrameStrobe  out  NumCols*MaxFramesPerCol    col c, frame f at c*MaxF+f
//   ConfigDone   out  1                          set by DESYNC, cleared by SYNC
//   ConfigErr    out  1                          sticky bad-address flag
//   dbg_state    out  state_e                    current FSM state
// -----------------------------------------------------------------------------
module config_frame_writer
    import config_frame_pkg::*;
#(
    parameter int NumRows         = 8,
    parameter int NumCols         = 8,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32
) (
    input  logic                                CLK,
    input  logic                                resetn,
    input  logic [WORD_W-1:0]                   in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                ConfigDone,
    output logic                                ConfigErr,
    output state_e                              dbg_state
);

    localparam int ROW_W   = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int STB_W   = NumCols * MaxFramesPerCol;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumRows - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e                 state_q,  state_d;
    logic [ROW_W-1:0]       row_q,    row_d;
    logic [COL_W-1:0]       col_q,    col_d;
    logic [FRAME_W-1:0]     frame_q,  frame_d;
    logic [WORD_W-1:0]      rows_q [NumRows];
    logic [WORD_W-1:0]      rows_d [NumRows];
    logic [STB_W-1:0]       strobe_q, strobe_d;
    logic                   done_q,   done_d;
    logic                   err_q,    err_d;

    logic                   ready_state;
    logic                   accept;
    logic [STB_W-1:0]       dec_onehot;
    logic                   dec_range_err;

    // ------------------------------------------------------------------
    // Address decode of the latched column/frame
    // ------------------------------------------------------------------
    frame_strobe_decoder #(
        .NumCols         (NumCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_decoder (
        .col       (col_q),
        .frame     (frame_q),
        .onehot    (dec_onehot),
        .range_err (dec_range_err)
    );

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign ready_state = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    // While resetn is low the state register sits at IDLE, which would
    // otherwise advertise ready; gate it so the source sees not-ready.
    assign in_ready    = ready_state & resetn;
    assign accept      = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        frame_d  = frame_q;
        rows_d   = rows_q;
        strobe_d = '0;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && in_data == SYNC_WORD) begin
                    state_d = ST_ADDR;
                    done_d  = 1'b0;
                end
            end

            ST_ADDR: begin
                if (accept) begin
                    // DESYNC also has bit 31 set, so it must be tested first.
                    if (in_data == DESYNC_WORD) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (is_addr_word(in_data)) begin
                        col_d   = in_data[COL_LSB +: COL_W];
                        frame_d = in_data[FRAME_LSB +: FRAME_W];
                        row_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                // Every word is payload here, SYNC/DESYNC values included.
                if (accept) begin
                    rows_d[row_q] = in_data;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = ST_STROBE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end

            ST_STROBE: begin
                // Decoder output is already zero for a bad address; the frame
                // still takes its STROBE/HOLD slots so timing is uniform.
                strobe_d = dec_onehot;
                if (dec_range_err) begin
                    err_d = 1'b1;
                end
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                state_d = ST_ADDR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            frame_q  <= '0;
            rows_q   <= '{default: '0};
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            rows_q   <= rows_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar r = 0; r < NumRows; r++) begin : g_frame_data
        assign FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[r];
    end

    assign FrameStrobe = strobe_q;
    assign ConfigDone  = done_q;
    assign ConfigErr   = err_q;
    assign dbg_state   = state_q;

endmodule : config_frame_writer
